// File: rtl/mem_store_unit_pkg.sv
// Shared RISC-V store types: funct3 store widths, store-engine states and the
// width-to-byte-count lookup used by the store unit and the decoder.
package mem_store_unit_pkg;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_width_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } store_state_t;

  // Zero marks an invalid funct3, so one lookup serves as both count and validity check.
  function automatic logic [2:0] store_bytes(input store_width_t w);
    case (w)
      SB:      store_bytes = 3'd1;
      SH:      store_bytes = 3'd2;
      SW:      store_bytes = 3'd4;
      default: store_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_unit.sv
// Byte-serial SB/SH/SW store engine: writes the low 1/2/4 bytes of a register
// value little-endian into byte-wide memory, one byte per clock.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  store_state_t      state;
  logic [1:0]        idx;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              error_q;
  logic [2:0]        req_bytes;

  assign req_bytes = store_bytes(store_width_t'(width));

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      nbytes  <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (req_bytes != 3'd0) begin
              addr_q <= addr;
              data_q <= data;
              nbytes <= req_bytes;
              idx    <= 2'd0;
              state  <= WRITE;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if ({1'b0, idx} == nbytes - 3'd1) begin
            state <= DONE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE: begin
          idx   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address arithmetic wraps at 2^ADDR_W, so a store may straddle the top of memory.
  assign mem_we    = (state == WRITE);
  assign mem_addr  = addr_q + ADDR_W'(idx);
  assign mem_wdata = data_q[{idx, 3'b000} +: 8];
  assign busy      = (state == WRITE) || (state == DONE);
  assign done      = (state == DONE);
  assign error     = error_q;

endmodule
